// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM states and counter width for the data-memory responder
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte/half/word lane merge for stores, lane select and extension for loads
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic        write,
  input  logic [1:0]  lane,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        align_error
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = word[{lane, 3'b000} +: 8];
  assign sel_half = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    store_word  = word;
    load_data   = '0;
    align_error = 1'b0;
    case (funct3)
      F3_B: begin
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
        load_data = {{24{sel_byte[7]}}, sel_byte};
      end
      F3_H: begin
        align_error = lane[0];
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = {{16{sel_half[15]}}, sel_half};
      end
      F3_W: begin
        align_error = (lane != 2'b00);
        store_word  = wdata;
        load_data   = word;
      end
      F3_BU: begin
        align_error = write;
        load_data   = {24'b0, sel_byte};
      end
      F3_HU: begin
        align_error = write | lane[0];
        load_data   = {16'b0, sel_half};
      end
      default: align_error = 1'b1;
    endcase
    // A rejected access must neither modify the word nor leak data.
    if (align_error) begin
      store_word = word;
      load_data  = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store slave with wait states, range checks and word storage
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  cap_write;
  logic [31:0]           cap_addr;
  logic [31:0]           cap_wdata;
  logic [2:0]            cap_funct3;
  logic [31:0]           mem [DEPTH_WORDS];

  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_funct3;
  logic        acc_in_range;
  logic [AW-1:0] acc_idx;
  logic [31:0] acc_word;
  logic [31:0] store_word;
  logic [31:0] load_data;
  logic        align_error;
  logic        acc_error;
  logic        do_access;

  // With zero wait states the access lands on the accept edge, so it reads the request pins directly.
  assign acc_write  = (state == IDLE) ? req_write  : cap_write;
  assign acc_addr   = (state == IDLE) ? req_addr   : cap_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;

  assign acc_in_range = (acc_addr[31:2] < DEPTH_LIMIT);
  assign acc_idx      = acc_addr[AW+1:2];
  assign acc_word     = acc_in_range ? mem[acc_idx] : '0;
  assign acc_error    = align_error | ~acc_in_range;

  assign do_access = (WAIT_CYCLES == 0) ? (state == IDLE && req_valid)
                                        : (state == WAIT && wait_cnt == WAIT_LAST);
  assign req_ready = (state == IDLE);

  dmem_lane_align u_lane_align (
    .word        (acc_word),
    .wdata       (acc_wdata),
    .funct3      (acc_funct3),
    .write       (acc_write),
    .lane        (acc_addr[1:0]),
    .store_word  (store_word),
    .load_data   (load_data),
    .align_error (align_error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_funct3 <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cap_write  <= req_write;
          cap_addr   <= req_addr;
          cap_wdata  <= req_wdata;
          cap_funct3 <= req_funct3;
          if (WAIT_CYCLES == 0) begin
            state <= RESP;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_CNT_W'(1);
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= RESP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (do_access) begin
        rsp_valid <= 1'b1;
        rsp_error <= acc_error;
        rsp_rdata <= (acc_write || acc_error) ? 32'h0 : load_data;
        if (acc_write && !acc_error) mem[acc_idx] <= store_word;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed bench against a byte-array reference model
module tb_dmem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [DEPTH_WORDS*4];

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH_WORDS*4; i++) mdl[i] = 8'h00;
  endfunction

  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int size;
    logic legal;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!w && (f3 == 3'd4 || f3 == 3'd5));
    er = !legal || ((a % size) != 0) || ((a >> 2) >= DEPTH_WORDS);
    rd = '0;
    if (!er) begin
      for (int i = 0; i < size; i++) begin
        if (w) mdl[int'(a) + i] = d[8*i +: 8];
        else   rd[8*i +: 8] = mdl[int'(a) + i];
      end
      if (!w && !f3[2] && size < 4 && rd[8*size-1])
        for (int i = size; i < 4; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input int hold,
                      output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat;
    model(w, a, d, f3, exp_rd, exp_er);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    // Junk request held high while busy must be ignored.
    req_write = 1'b1; req_addr = $urandom_range(0, 63); req_wdata = $urandom; req_funct3 = 3'd2;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, WAIT_CYCLES + 1);
    rd = rsp_rdata;
    er = rsp_error;
    check("rsp_rdata", rd, exp_rd);
    check("rsp_error", er, exp_er);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_error", rsp_error, er);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    req_valid = 0;
    check("rsp_valid_clear", rsp_valid, 0);
    check("req_ready_after", req_ready, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0; rsp_ready = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_error", rsp_error, 0);

    xact(1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er); check("sw_err", er, 0);
    xact(0, 32'h10, 32'h0, 3'b010, 0, rd, er);        check("lw_10", rd, 32'hDEADBEEF);
    xact(1, 32'h11, 32'h80, 3'b000, 0, rd, er);       check("sb_err", er, 0);
    xact(0, 32'h11, 32'h0, 3'b000, 1, rd, er);        check("lb_11", rd, 32'hFFFFFF80);
    xact(0, 32'h11, 32'h0, 3'b100, 0, rd, er);        check("lbu_11", rd, 32'h00000080);
    xact(0, 32'h10, 32'h0, 3'b010, 0, rd, er);        check("lw_merged", rd, 32'hDEAD80EF);
    xact(1, 32'h13, 32'hFFFF, 3'b001, 0, rd, er);     check("sh_mis_err", er, 1);
    xact(0, 32'h10, 32'h0, 3'b010, 0, rd, er);        check("lw_after_sh", rd, 32'hDEAD80EF);
    xact(0, 32'h12, 32'h0, 3'b010, 0, rd, er);        check("lw_mis_err", er, 1); check("lw_mis_rd", rd, 0);
    xact(0, 32'h400, 32'h0, 3'b010, 0, rd, er);       check("lw_range_err", er, 1);
    xact(0, 32'h10, 32'h0, 3'b011, 0, rd, er);        check("f3_011_err", er, 1);
    xact(1, 32'h10, 32'h55, 3'b100, 0, rd, er);       check("sbu_err", er, 1);
    xact(0, 32'h10, 32'h0, 3'b010, 5, rd, er);        check("lw_hold", rd, 32'hDEAD80EF);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFC;
      else if ($urandom_range(0, 3) == 0) a = {$urandom_range(250, 259), 2'b00} | $urandom_range(0, 3);
      else a = {$urandom_range(0, 7), 2'b00} | $urandom_range(0, 3);
      xact(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 2), rd, er);
    end

    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_clear();
    check("midreset_rsp_valid", rsp_valid, 0);
    check("midreset_req_ready", req_ready, 1);
    xact(0, 32'h20, 32'h0, 3'b010, 0, rd, er);        check("lw_20_cleared", rd, 32'h0);
    xact(0, 32'h10, 32'h0, 3'b010, 0, rd, er);        check("lw_10_cleared", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder: the slave end of the core's load/store interface, answering requests issued by the processor datapath. Accepts one request at a time over a valid/ready handshake. Inserts a configurable number of wait states, then returns read data or a write acknowledgement with an error flag. Performs RISC-V byte/halfword/word lane selection, sign/zero extension, and alignment and range checks internally.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words of storage
WAIT_CYCLES, 2, wait states between request accept and response (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; low byte/half used for SB/SH
req_funct3  input  3  access size/sign (RISC-V load/store funct3)
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
rsp_error  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, wait counter=0, all storage words=0.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture write, addr, wdata and funct3.
  - Go to WAIT if WAIT_CYCLES>0, else go directly to RESP.
- WAIT:
  - req_ready=0.
  - Counter runs 1..WAIT_CYCLES.
  - On the final count, perform the access and go to RESP.
- Access (single edge, entering RESP):
  - Loads latch rsp_rdata.
  - Stores update storage.
  - rsp_valid=1 from the first RESP cycle.
- RESP:
  - rsp_valid, rsp_rdata and rsp_error are held stable while rsp_ready=0.
  - On rsp_ready=1, go to IDLE and clear rsp_valid next cycle.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Latency: accept edge to rsp_valid is WAIT_CYCLES+1 cycles. Minimum request period is WAIT_CYCLES+2 cycles.
- funct3 encoding:
  - 000 = LB/SB, 001 = LH/SH, 010 = LW/SW.
  - 100 = LBU, 101 = LHU (load only).
  - Any other code, or 100/101 with req_write=1, gives an error.
- Addressing is little-endian: word index = addr[31:2]; byte lane = addr[1:0].
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Violation gives an error.
- Range: word index >= DEPTH_WORDS gives an error. No wrap-around.
- On error: storage is unchanged, rsp_rdata=0, rsp_error=1. The response still completes through the normal handshake.
- Store merge:
  - SB writes only the addressed byte.
  - SH writes only the addressed half.
  - SW writes the full word.
  - Other bytes are preserved.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Reset mid-operation:
  - Any captured but uncommitted store is discarded.
  - A pending response is dropped (rsp_valid=0 after the reset edge).
  - Storage is cleared.
- req_* inputs are ignored outside IDLE. req_valid asserted during WAIT or RESP is neither captured nor lost, since req_ready=0 there.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the state enum {IDLE, WAIT, RESP}
  - the WAIT_CYCLES counter width constant
- One combinational sub-module, dmem_lane_align. It takes the stored word, the request fields and addr[1:0], and produces the merged store word, the extended load value and the alignment/funct3 error.
- dmem_responder holds the FSM, the counter, the request capture registers and the storage array.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> rsp_rdata=0xDEADBEEF, rsp_error=0; rsp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2).
- After that word, SB addr=0x11 wdata=0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
- SH addr=0x13 -> rsp_error=1 and storage unchanged (LW 0x10 still 0xDEAD80EF); LW addr=0x12 -> rsp_error=1, rsp_rdata=0.
- LW addr=0x400 (DEPTH_WORDS=256) -> rsp_error=1; funct3=011 -> rsp_error=1; SB with funct3=100 -> rsp_error=1, no write.
- Hold rsp_ready=0 for 5 cycles during an LW -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; release -> req_ready=1 the next cycle.
- Assert reset during WAIT of SW addr=0x20 wdata=0x12345678 -> rsp_valid=0 after the edge and req_ready=1; subsequent LW 0x20 -> 0x00000000.
